// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Program counter and fetch stage feeding the IF/ID register. Drives a byte
//   address into a combinational-read instruction memory. It latches the
//   returned word together with its PC. It also handles stall, branch/jump
//   redirect and a sticky halt.
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   imem_addr        byte address to instruction memory (current PC)
//   imem_data        instruction word for imem_addr, same cycle
//   stall            decode not ready: hold PC and IF/ID register
//   redirect_valid   taken branch/jump: load redirect_target
//   redirect_target  new PC (byte address)
//   if_instr         latched instruction
//   if_pc            PC of if_instr
//   if_valid         if_instr/if_pc hold a live instruction
//   halted           sticky: halt opcode fetched, fetching stopped
//   align_err        sticky: misaligned or out-of-range redirect seen
//   fetch_count      instructions delivered, saturating at 16'hFFFF
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter int          IMEM_BYTES  = 512,
  parameter logic [5:0]  HALT_OPCODE = 6'b010110
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        halted,
  output logic        align_err,
  output logic [15:0] fetch_count
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HALT = 1'b1;

  // IMEM_BYTES is a power of two, so wrapping is a mask.
  localparam logic [31:0] ADDR_MASK = 32'(IMEM_BYTES - 1);

  logic [0:0]  state_r;
  logic [31:0] pc_r;
  logic [31:0] pc_inc;
  logic [31:0] redirect_pc;
  logic        redirect_bad;
  logic        is_halt_word;

  assign imem_addr = pc_r;
  assign halted    = (state_r == HALT);

  always_comb begin
    pc_inc       = (pc_r + 32'd4) & ADDR_MASK;
    redirect_pc  = {redirect_target[31:2], 2'b00} & ADDR_MASK;
    redirect_bad = (redirect_target[1:0] != 2'b00) ||
                   (redirect_target >= 32'(IMEM_BYTES));
    is_halt_word = (imem_data[31:26] == HALT_OPCODE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RUN;
      pc_r        <= RESET_PC;
      if_instr    <= '0;
      if_pc       <= '0;
      if_valid    <= 1'b0;
      align_err   <= 1'b0;
      fetch_count <= '0;
    end else if (redirect_valid && state_r == RUN) begin
      // Redirect wins over stall; the word fetched this cycle is dropped,
      // including a halt opcode.
      pc_r     <= redirect_pc;
      if_valid <= 1'b0;
      if (redirect_bad) begin
        align_err <= 1'b1;
      end
    end else if (stall) begin
      // Hold everything, including if_valid.
    end else if (state_r == RUN) begin
      if_instr <= imem_data;
      if_pc    <= pc_r;
      if_valid <= 1'b1;
      if (fetch_count != '1) begin
        fetch_count <= fetch_count + 16'd1;
      end
      if (is_halt_word) begin
        state_r <= HALT;
      end else begin
        pc_r <= pc_inc;
      end
    end else begin
      // HALT: the halt word was delivered last cycle; only bubbles from now on.
      if_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit
//   Directed bench for instruction_fetch_unit. A word-array model of the
//   instruction memory is read combinationally at imem_addr. Expected values
//   are hand-computed per step.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        halted;
  logic        align_err;
  logic [15:0] fetch_count;

  logic [31:0] mem [128];

  int unsigned n_cmp;
  int unsigned n_err;

  instruction_fetch_unit #(
    .RESET_PC   (32'd0),
    .IMEM_BYTES (512),
    .HALT_OPCODE(6'b010110)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_valid       (if_valid),
    .halted         (halted),
    .align_err      (align_err),
    .fetch_count    (fetch_count)
  );

  assign imem_data = mem[imem_addr[8:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] tgt, input logic stl);
    redirect_valid  = 1'b1;
    redirect_target = tgt;
    stall           = stl;
    tick();
    redirect_valid  = 1'b0;
    redirect_target = '0;
    stall           = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 | 32'(i * 4);
    mem[72 / 4] = 32'h5800_0000;

    rst_n           = 1'b0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    #12;
    check_eq("rst_addr",   imem_addr, 32'd0);
    check_eq("rst_valid",  {31'd0, if_valid}, 32'd0);
    check_eq("rst_instr",  if_instr, 32'd0);
    check_eq("rst_halted", {31'd0, halted}, 32'd0);
    check_eq("rst_fc",     {16'd0, fetch_count}, 32'd0);
    rst_n = 1'b1;

    // Free run
    tick();
    check_eq("run1_pc",    if_pc, 32'd0);
    check_eq("run1_addr",  imem_addr, 32'd4);
    tick();
    check_eq("run2_addr",  imem_addr, 32'd8);
    check_eq("run2_pc",    if_pc, 32'd4);
    check_eq("run2_valid", {31'd0, if_valid}, 32'd1);
    check_eq("run2_fc",    {16'd0, fetch_count}, 32'd2);
    tick();
    check_eq("run3_addr",  imem_addr, 32'd12);

    // Stall two cycles at pc 12
    stall = 1'b1;
    tick();
    tick();
    check_eq("stl_addr",   imem_addr, 32'd12);
    check_eq("stl_pc",     if_pc, 32'd8);
    check_eq("stl_instr",  if_instr, 32'h1000_0008);
    check_eq("stl_valid",  {31'd0, if_valid}, 32'd1);
    check_eq("stl_fc",     {16'd0, fetch_count}, 32'd3);
    stall = 1'b0;
    tick();
    check_eq("unstl_pc",   if_pc, 32'd12);
    check_eq("unstl_fc",   {16'd0, fetch_count}, 32'd4);

    // Redirect overrides stall
    redirect(32'd20, 1'b1);
    check_eq("rd_addr",    imem_addr, 32'd20);
    check_eq("rd_valid",   {31'd0, if_valid}, 32'd0);
    check_eq("rd_fc",      {16'd0, fetch_count}, 32'd4);
    check_eq("rd_aerr",    {31'd0, align_err}, 32'd0);
    tick();
    check_eq("rd_pc",      if_pc, 32'd20);
    check_eq("rd_instr",   if_instr, 32'h1000_0014);
    check_eq("rd_fc2",     {16'd0, fetch_count}, 32'd5);

    // Misaligned redirect
    redirect(32'h15, 1'b0);
    check_eq("mis_addr",   imem_addr, 32'h14);
    check_eq("mis_aerr",   {31'd0, align_err}, 32'd1);
    tick();
    check_eq("mis_pc",     if_pc, 32'h14);
    check_eq("mis_sticky", {31'd0, align_err}, 32'd1);

    // Out-of-range redirect wraps to 0
    redirect(32'h200, 1'b0);
    check_eq("oor_addr",   imem_addr, 32'd0);
    check_eq("oor_aerr",   {31'd0, align_err}, 32'd1);

    // Wrap-around from 508
    redirect(32'd508, 1'b0);
    check_eq("wrap_addr0", imem_addr, 32'd508);
    tick();
    check_eq("wrap_pc",    if_pc, 32'd508);
    check_eq("wrap_addr1", imem_addr, 32'd0);
    tick();
    check_eq("wrap_pc2",   if_pc, 32'd0);
    check_eq("wrap_fc",    {16'd0, fetch_count}, 32'd8);

    // Halt word at 72
    redirect(32'd72, 1'b0);
    check_eq("hlt_addr0",  imem_addr, 32'd72);
    tick();
    check_eq("hlt_pc",     if_pc, 32'd72);
    check_eq("hlt_instr",  if_instr, 32'h5800_0000);
    check_eq("hlt_valid",  {31'd0, if_valid}, 32'd1);
    check_eq("hlt_halted", {31'd0, halted}, 32'd1);
    check_eq("hlt_addr1",  imem_addr, 32'd72);
    check_eq("hlt_fc",     {16'd0, fetch_count}, 32'd9);
    tick();
    check_eq("hlt_bubble", {31'd0, if_valid}, 32'd0);
    check_eq("hlt_addr2",  imem_addr, 32'd72);
    redirect(32'd0, 1'b0);
    check_eq("hlt_ignrd",  imem_addr, 32'd72);
    check_eq("hlt_stick",  {31'd0, halted}, 32'd1);
    check_eq("hlt_fc2",    {16'd0, fetch_count}, 32'd9);

    // Async reset mid-operation, between clock edges
    #1;
    rst_n = 1'b0;
    #2;
    check_eq("ar_addr",    imem_addr, 32'd0);
    check_eq("ar_halted",  {31'd0, halted}, 32'd0);
    check_eq("ar_aerr",    {31'd0, align_err}, 32'd0);
    check_eq("ar_fc",      {16'd0, fetch_count}, 32'd0);
    check_eq("ar_pc",      if_pc, 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("post_valid", {31'd0, if_valid}, 32'd1);
    check_eq("post_addr",  imem_addr, 32'd4);
    check_eq("post_fc",    {16'd0, fetch_count}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
